// File: rtl/apb_multi_slave_resp24_pkg.sv
// Shared types and helpers for the multi-channel APB3 slave responder.
package apb_slave_pkg24;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int PROTO_MULTI   = 0;
  localparam int PROTO_NOSETUP = 1;
  localparam int PROTO_MIDACC  = 2;

  localparam int SEL_MAX = 32;

  // Isolates the lowest set bit of a select vector (two's-complement trick).
  function automatic logic [SEL_MAX-1:0] onehot_lowest24(input logic [SEL_MAX-1:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/apb_multi_slave_resp24_reg_bank.sv
// One slave's register bank: single write port, asynchronous read, cleared on reset.
module apb_reg_bank24
  import apb_slave_pkg24::*;
#(
  parameter int DEPTH24 = 16,
  parameter int WIDTH24 = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(DEPTH24)-1:0] waddr,
  input  logic [WIDTH24-1:0]         wdata,
  input  logic [$clog2(DEPTH24)-1:0] raddr,
  output logic [WIDTH24-1:0]         rdata
);

  logic [WIDTH24-1:0] mem_r [DEPTH24];

  // Storage array with write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH24; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/apb_multi_slave_resp24.sv
// Reactive APB3 slave for NUM_SLAVES24 select lines, each backed by its own register bank,
// with programmable wait states, address-error responses and sticky protocol-violation flags.
module apb_multi_slave_resp24
  import apb_slave_pkg24::*;
#(
  parameter int NUM_SLAVES24   = 4,
  parameter int PADDR_WIDTH24  = 32,
  parameter int PWDATA_WIDTH24 = 32,
  parameter int PRDATA_WIDTH24 = 32,
  parameter int DEPTH24        = 16,
  parameter int MAX_WAIT24     = 15,
  localparam int WW24          = $clog2(MAX_WAIT24 + 1)
) (
  input  logic                      pclock24,
  input  logic                      preset24,
  input  logic [PADDR_WIDTH24-1:0]  paddr24,
  input  logic                      prwd24,
  input  logic [PWDATA_WIDTH24-1:0] pwdata24,
  input  logic [NUM_SLAVES24-1:0]   psel24,
  input  logic                      penable24,
  input  logic [WW24-1:0]           wait_cfg24,
  output logic [PRDATA_WIDTH24-1:0] prdata24,
  output logic                      pready24,
  output logic                      pslverr24,
  output logic [2:0]                proto_err24
);

  localparam int AW = $clog2(DEPTH24);
  localparam int IW = (NUM_SLAVES24 > 1) ? $clog2(NUM_SLAVES24) : 1;
  localparam logic [PADDR_WIDTH24-1:0] ADDR_LIMIT = PADDR_WIDTH24'(DEPTH24 * 4);
  localparam logic [WW24-1:0] WAIT_CAP = WW24'(MAX_WAIT24);

  state_t                    state_r;
  logic [IW-1:0]             idx_r;
  logic [PADDR_WIDTH24-1:0]  addr_r;
  logic [NUM_SLAVES24-1:0]   sel_r;
  logic                      write_r;
  logic [PWDATA_WIDTH24-1:0] wdata_r;
  logic [WW24-1:0]           cnt_r;
  logic                      aerr_r;

  logic [SEL_MAX-1:0]        low_s;
  logic [IW-1:0]             low_idx_s;
  logic                      multi_s;
  logic                      addr_err_s;
  logic [WW24-1:0]           wait_eff_s;
  logic [IW-1:0]             rd_idx_s;
  logic [AW-1:0]             rd_word_s;
  logic [PWDATA_WIDTH24-1:0] rd_data_s;
  logic                      commit_s;
  logic [PWDATA_WIDTH24-1:0] bank_rdata_s [NUM_SLAVES24];

  // Setup-phase decode: selected channel, error classification and read addressing
  always_comb begin
    low_s      = onehot_lowest24(SEL_MAX'(psel24));
    multi_s    = (|psel24) && (low_s != SEL_MAX'(psel24));
    low_idx_s  = '0;
    for (int i = 0; i < NUM_SLAVES24; i++) begin
      low_idx_s = low_idx_s | (low_s[i] ? IW'(i) : IW'(0));
    end
    addr_err_s = (paddr24[1:0] != 2'b00) || (paddr24 >= ADDR_LIMIT);
    wait_eff_s = (wait_cfg24 > WAIT_CAP) ? WAIT_CAP : wait_cfg24;
    case (state_r)
      IDLE: begin
        rd_idx_s  = low_idx_s;
        rd_word_s = paddr24[AW+1:2];
      end
      ACCESS: begin
        rd_idx_s  = idx_r;
        rd_word_s = addr_r[AW+1:2];
      end
      default: begin
        rd_idx_s  = idx_r;
        rd_word_s = addr_r[AW+1:2];
      end
    endcase
    rd_data_s = bank_rdata_s[rd_idx_s];
    commit_s  = (state_r == ACCESS) && pready24 && (|psel24) && write_r && !aerr_r;
  end

  for (genvar g = 0; g < NUM_SLAVES24; g++) begin : g_bank
    apb_reg_bank24 #(
      .DEPTH24 (DEPTH24),
      .WIDTH24 (PWDATA_WIDTH24)
    ) u_bank (
      .clk   (pclock24),
      .rst_n (preset24),
      .we    (commit_s && (idx_r == IW'(g))),
      .waddr (addr_r[AW+1:2]),
      .wdata (wdata_r),
      .raddr (rd_word_s),
      .rdata (bank_rdata_s[g])
    );
  end

  // Transfer FSM with registered response outputs
  always_ff @(posedge pclock24 or negedge preset24) begin
    if (!preset24) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      addr_r      <= '0;
      sel_r       <= '0;
      write_r     <= 1'b0;
      wdata_r     <= '0;
      cnt_r       <= '0;
      aerr_r      <= 1'b0;
      prdata24    <= '0;
      pready24    <= 1'b0;
      pslverr24   <= 1'b0;
      proto_err24 <= 3'b000;
    end else begin
      case (state_r)
        IDLE: begin
          if ((|psel24) && !penable24) begin
            idx_r     <= low_idx_s;
            addr_r    <= paddr24;
            sel_r     <= psel24;
            write_r   <= prwd24;
            wdata_r   <= pwdata24;
            cnt_r     <= wait_eff_s;
            aerr_r    <= addr_err_s;
            pready24  <= (wait_eff_s == WW24'(0));
            pslverr24 <= (wait_eff_s == WW24'(0)) && addr_err_s;
            prdata24  <= ((wait_eff_s == WW24'(0)) && !prwd24 && !addr_err_s) ?
                         PRDATA_WIDTH24'(rd_data_s) : '0;
            if (multi_s) begin
              proto_err24[PROTO_MULTI] <= 1'b1;
            end
            state_r   <= ACCESS;
          end else if (penable24) begin
            proto_err24[PROTO_NOSETUP] <= 1'b1;
          end
        end
        ACCESS: begin
          if (!(|psel24)) begin
            // Master abandoned the transfer: no write, no response.
            proto_err24[PROTO_MIDACC] <= 1'b1;
            pready24  <= 1'b0;
            pslverr24 <= 1'b0;
            prdata24  <= '0;
            state_r   <= IDLE;
          end else begin
            if ((psel24 != sel_r) || (paddr24 != addr_r)) begin
              proto_err24[PROTO_MIDACC] <= 1'b1;
            end
            if (pready24) begin
              pready24  <= 1'b0;
              pslverr24 <= 1'b0;
              prdata24  <= '0;
              state_r   <= IDLE;
            end else begin
              cnt_r <= cnt_r - WW24'(1);
              if (cnt_r == WW24'(1)) begin
                pready24  <= 1'b1;
                pslverr24 <= aerr_r;
                prdata24  <= (aerr_r || write_r) ? '0 : PRDATA_WIDTH24'(rd_data_s);
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_resp24.sv
// Directed scoreboard bench: transfers push expected responses, a negedge monitor pops and compares.
module tb_apb_multi_slave_resp24;

  logic        pclock24 = 1'b0;
  logic        preset24 = 1'b0;
  logic [31:0] paddr24  = 32'd0;
  logic        prwd24   = 1'b0;
  logic [31:0] pwdata24 = 32'd0;
  logic [3:0]  psel24   = 4'd0;
  logic        penable24 = 1'b0;
  logic [3:0]  wait_cfg24 = 4'd0;
  logic [31:0] prdata24;
  logic        pready24;
  logic        pslverr24;
  logic [2:0]  proto_err24;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          waits;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  apb_multi_slave_resp24 dut (
    .pclock24    (pclock24),
    .preset24    (preset24),
    .paddr24     (paddr24),
    .prwd24      (prwd24),
    .pwdata24    (pwdata24),
    .psel24      (psel24),
    .penable24   (penable24),
    .wait_cfg24  (wait_cfg24),
    .prdata24    (prdata24),
    .pready24    (pready24),
    .pslverr24   (pslverr24),
    .proto_err24 (proto_err24)
  );

  always #5 pclock24 = ~pclock24;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: counts wait cycles and checks each completed response against the queue head
  initial begin
    int   wait_seen;
    exp_t e;
    wait_seen = 0;
    forever begin
      @(negedge pclock24);
      if (preset24 && penable24 && (psel24 != 4'd0)) begin
        if (pready24) begin
          if (q.size() == 0) begin
            chk("unexpected_response", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("prdata", prdata24, e.rd);
            chk("pslverr", {31'd0, pslverr24}, {31'd0, e.err});
            chk("wait_cycles", wait_seen, e.waits);
          end
          wait_seen = 0;
        end else begin
          wait_seen++;
        end
      end else begin
        wait_seen = 0;
      end
    end
  end

  task automatic setup_phase(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                             input logic [31:0] wd, input logic [3:0] wt);
    @(posedge pclock24); #1;
    psel24 = sel; paddr24 = addr; prwd24 = wr; pwdata24 = wd; wait_cfg24 = wt; penable24 = 1'b0;
    @(posedge pclock24); #1;
    penable24 = 1'b1;
  endtask

  task automatic wait_ready(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge pclock24);
      if (pready24) seen = 1'b1;
    end
    if (!seen) begin
      chk("pready_timeout", 32'd0, 32'd1);
      if (q.size() > 0) void'(q.pop_front());
    end
  endtask

  task automatic apb(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                     input logic [31:0] wd, input logic [3:0] wt,
                     input logic [31:0] erd, input logic eerr);
    exp_t e;
    bit   seen;
    e.rd = erd; e.err = eerr; e.waits = int'(wt);
    q.push_back(e);
    setup_phase(sel, addr, wr, wd, wt);
    wait_ready(seen);
    @(posedge pclock24); #1;
    psel24 = 4'd0; penable24 = 1'b0; wait_cfg24 = 4'd9;
  endtask

  initial begin
    exp_t e;
    bit   seen;
    repeat (3) @(posedge pclock24);
    @(negedge pclock24);
    chk("rst_pready", {31'd0, pready24}, 32'd0);
    chk("rst_pslverr", {31'd0, pslverr24}, 32'd0);
    chk("rst_prdata", prdata24, 32'd0);
    chk("rst_proto", {29'd0, proto_err24}, 32'd0);
    @(posedge pclock24); #1;
    preset24 = 1'b1;

    // Zero-wait write then read
    apb(4'b0010, 32'h8, 1'b1, 32'hDEADBEEF, 4'd0, 32'h0, 1'b0);
    apb(4'b0010, 32'h8, 1'b0, 32'h0, 4'd0, 32'hDEADBEEF, 1'b0);

    // Wait states on an untouched word
    apb(4'b0001, 32'h0, 1'b0, 32'h0, 4'd3, 32'h0, 1'b0);

    // Address errors must not disturb word 0
    apb(4'b0001, 32'h0, 1'b1, 32'hCAFE0000, 4'd0, 32'h0, 1'b0);
    apb(4'b0001, 32'h2, 1'b1, 32'h00000BAD, 4'd0, 32'h0, 1'b1);
    apb(4'b0001, 32'h40, 1'b1, 32'h00000BAD, 4'd2, 32'h0, 1'b1);
    apb(4'b0001, 32'h40, 1'b0, 32'h0, 4'd0, 32'h0, 1'b1);
    apb(4'b0001, 32'h0, 1'b0, 32'h0, 4'd1, 32'hCAFE0000, 1'b0);
    @(negedge pclock24);
    chk("proto_clean", {29'd0, proto_err24}, 32'd0);

    // Multi-hot select goes to the lowest slave
    apb(4'b0110, 32'h4, 1'b1, 32'h55, 4'd0, 32'h0, 1'b0);
    @(negedge pclock24);
    chk("proto_multi", {29'd0, proto_err24}, 32'h1);
    apb(4'b0010, 32'h4, 1'b0, 32'h0, 4'd0, 32'h55, 1'b0);
    apb(4'b0100, 32'h4, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);

    // Select dropped in the second access cycle
    setup_phase(4'b0001, 32'hC, 1'b1, 32'h1234, 4'd5);
    @(posedge pclock24); #1;
    psel24 = 4'd0; penable24 = 1'b0;
    @(posedge pclock24);
    @(negedge pclock24);
    chk("proto_abort", {29'd0, proto_err24}, 32'h5);
    chk("abort_pready", {31'd0, pready24}, 32'd0);
    apb(4'b0001, 32'hC, 1'b0, 32'h0, 4'd2, 32'h0, 1'b0);

    // Enable without a setup phase
    @(posedge pclock24); #1;
    penable24 = 1'b1;
    @(posedge pclock24); #1;
    penable24 = 1'b0;
    @(negedge pclock24);
    chk("proto_nosetup", {29'd0, proto_err24}, 32'h7);

    // Reset while a waited write is presenting pready
    apb(4'b1000, 32'h4, 1'b1, 32'h11111111, 4'd0, 32'h0, 1'b0);
    apb(4'b1000, 32'h4, 1'b0, 32'h0, 4'd0, 32'h11111111, 1'b0);
    e.rd = 32'h0; e.err = 1'b0; e.waits = 2;
    q.push_back(e);
    setup_phase(4'b1000, 32'h4, 1'b1, 32'hAAAA, 4'd2);
    wait_ready(seen);
    #1 preset24 = 1'b0;
    #1;
    chk("async_rst_pready", {31'd0, pready24}, 32'd0);
    chk("async_rst_proto", {29'd0, proto_err24}, 32'd0);
    @(posedge pclock24); #1;
    psel24 = 4'd0; penable24 = 1'b0;
    @(posedge pclock24); #1;
    preset24 = 1'b1;
    apb(4'b1000, 32'h4, 1'b0, 32'h0, 4'd0, 32'h0, 1'b0);

    repeat (2) @(negedge pclock24);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
